trace_checker: RTL and testbench
================================

// Module: trace_checker
// PURPOSE
//  Consumer end of the CPU retire-trace stream. Takes per-cycle retire events from mod_CPU
//  (PC, regwrite, dst reg/data, mem read/write, addr/data, hlt) and classifies each one into a
//  trace record: REG, LD, ST, NOP or HLT. Compares each record in order against a golden record
//  stream (valid/ready) fed by the bench or a trace ROM. Reports pass/fail, instruction count and
//  mismatch count. Synthesizable; sits beside mod_CPU in the top-level bench.
// PARAMETERS
//  DEPTH      8  observed-record FIFO entries (power of 2, >=2)
//  STOP_ON_ERR 1 1: enter FAIL on first mismatch; 0: count mismatches and keep running
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  obs_pc      in   16  PC of retiring instruction
//  obs_regwr   in   1   register write
//  obs_wreg    in   4   destination register
//  obs_wdata   in   16  destination data
//  obs_memrd   in   1   memory read
//  obs_memwr   in   1   memory write
//  obs_addr    in   16  memory address
//  obs_mdata   in   16  store data
//  obs_hlt     in   1   halt retiring
//  obs_en      in   1   sample obs_* this cycle (tie to ~rst of CPU)
//  exp_valid   in   1   golden record valid
//  exp_rec     in   REC_W golden record {type[2:0],pc,reg[3:0],value,addr}
//  exp_ready   out  1   golden record consumed this cycle
//  done        out  1   HLT record matched
//  fail        out  1   sticky: mismatch (STOP_ON_ERR=1) or FIFO overflow
//  inst_cnt    out  32  records compared
//  err_cnt     out  16  mismatching records, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset: exp_ready=0, done=0, fail=0, inst_cnt=0, err_cnt=0, FIFO empty, state=RUN.
//  - Classification when obs_en: regwr&memrd->LD(value=wdata, addr); regwr->REG; hlt->HLT;
//    memwr->ST(value=mdata, addr); otherwise NOP. Fields unused by a type are zeroed before
//    push/compare. After HLT is pushed, further obs_en events are ignored.
//  - Push: one classified record per obs_en cycle into the FIFO. Push while full with no pop in
//    the same cycle -> overflow: fail=1, state=FAIL. Push and pop together while full is legal.
//  - Compare: in RUN, when FIFO non-empty & exp_valid -> exp_ready=1 (combinational), pop,
//    inst_cnt+1. Compare is on the whole record, bit-exact.
//  - Latency: an observed event can be compared at the earliest one cycle after obs_en.
//    exp_ready is never asserted while the FIFO is empty.
//  - FSM: RUN -> DONE on matched HLT; RUN -> FAIL on mismatch (STOP_ON_ERR=1) or overflow.
//    A mismatched HLT -> FAIL regardless of STOP_ON_ERR. DONE and FAIL are terminal until
//    rst; exp_ready=0 in both. STOP_ON_ERR=0: mismatch increments err_cnt and stays in RUN.
//  - rst mid-run: immediate clear of all state, including the FIFO contents.
// CONFIGURATION
//  TRACE_CHECK_CAPTURE_EN defined: adds outputs bad_inum[31:0], bad_obs[REC_W-1:0],
//    bad_exp[REC_W-1:0]. They latch the first mismatch (inst_cnt before increment, both records)
//    and hold until rst; reset value 0. Not defined: the ports and registers are absent.
// STRUCTURE
//  - Shared header trace_defs.vh holds:
//    - REC_W = 3+16+4+16+16 = 55
//    - field offset localparams
//    - type codes TR_REG=0, TR_LD=1, TR_ST=2, TR_NOP=3, TR_HLT=4
//    - FSM state encodings
//  - Sub-module trace_fifo: a synchronous FIFO, REC_W wide, DEPTH deep, with full/empty and
//    simultaneous push/pop support. Classification and compare logic live in the top level.
// TESTING
//  1. REG match: obs regwr, pc=0x0002, wreg=3, wdata=0x1234; exp {REG,0x0002,3,0x1234,0}
//     -> inst_cnt=1, err_cnt=0.
//  2. LD/ST: obs regwr+memrd, addr=0x0010, wdata=0xBEEF; then memwr, addr=0x0012,
//     mdata=0x00AA; matching exps -> both consumed in order, fail=0.
//  3. Mismatch: exp value 0x1235 vs obs 0x1234, STOP_ON_ERR=1 -> fail=1 next cycle,
//     exp_ready=0 afterwards. With TRACE_CHECK_CAPTURE_EN: bad_inum=0.
//  4. Backpressure: 8 obs events with exp_valid=0, DEPTH=8 -> no fail. A 9th event -> fail=1.
//     Repeat with exp_valid high on the 9th cycle -> no fail.
//  5. HLT: obs_hlt at pc=0x001E, exp {HLT,0x001E,...} -> done=1, later obs_en ignored.
//     A HLT pc mismatch -> fail=1.
//  6. Reset mid-run after 3 records -> all outputs 0, FIFO empty, a fresh REG match passes.

Source files
------------

// File: rtl/trace_checker_pkg.sv
// Shared definitions for the retire-trace checker: record layout, type codes, FSM states.
package trace_checker_pkg;

   localparam int unsigned TYPE_W = 3;
   localparam int unsigned PC_W   = 16;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned VAL_W  = 16;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned REC_W  = TYPE_W + PC_W + REG_W + VAL_W + ADDR_W;

   // Bit offsets of each field inside a flattened record
   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned VAL_LSB  = ADDR_LSB + ADDR_W;
   localparam int unsigned REG_LSB  = VAL_LSB + VAL_W;
   localparam int unsigned PC_LSB   = REG_LSB + REG_W;
   localparam int unsigned TYPE_LSB = PC_LSB + PC_W;

   typedef enum logic [TYPE_W-1:0] {
      TR_REG = 3'd0,
      TR_LD  = 3'd1,
      TR_ST  = 3'd2,
      TR_NOP = 3'd3,
      TR_HLT = 3'd4
   } tr_type_e;

   typedef struct packed {
      tr_type_e          typ;
      logic [PC_W-1:0]   pc;
      logic [REG_W-1:0]  rg;
      logic [VAL_W-1:0]  value;
      logic [ADDR_W-1:0] addr;
   } trace_rec_t;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DONE = 2'd1,
      ST_FAIL = 2'd2
   } state_e;

endpackage

// File: rtl/trace_checker_if.sv
// Retire-event stream from the CPU plus the golden-record valid/ready stream.
// master: producer side (CPU/bench); slave: the checker.
interface trace_checker_if;
   import trace_checker_pkg::*;

   logic        obs_en;
   logic [15:0] obs_pc;
   logic        obs_regwr;
   logic [3:0]  obs_wreg;
   logic [15:0] obs_wdata;
   logic        obs_memrd;
   logic        obs_memwr;
   logic [15:0] obs_addr;
   logic [15:0] obs_mdata;
   logic        obs_hlt;
   logic        exp_valid;
   trace_rec_t  exp_rec;
   logic        exp_ready;

   modport master (
      output obs_en, obs_pc, obs_regwr, obs_wreg, obs_wdata, obs_memrd,
             obs_memwr, obs_addr, obs_mdata, obs_hlt, exp_valid, exp_rec,
      input  exp_ready
   );

   modport slave (
      input  obs_en, obs_pc, obs_regwr, obs_wreg, obs_wdata, obs_memrd,
             obs_memwr, obs_addr, obs_mdata, obs_hlt, exp_valid, exp_rec,
      output exp_ready
   );
endinterface

// File: rtl/trace_checker_fifo.sv
// Synchronous record FIFO with simultaneous push/pop.
// Ports: clk, rst (async active-high), push/wr_data, pop, rd_data_c (head), full_c, empty_c.
// Caller must not push while full without popping, nor pop while empty.
module trace_checker_fifo
   import trace_checker_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  trace_rec_t wr_data,
   input  logic       pop,
   output trace_rec_t rd_data_c,
   output logic       full_c,
   output logic       empty_c
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   trace_rec_t  mem [DEPTH];

   // Pointers carry one extra wrap bit to tell full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; pointer reset empties the FIFO
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wr_data;
   end

   assign rd_data_c = mem[rptr[AW-1:0]];
   assign empty_c   = (wptr == rptr);
   assign full_c    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/trace_checker.sv
// Classifies CPU retire events into trace records, queues them, and compares them in order
// against a golden record stream.
// Ports: clk, rst (async active-high); tif (slave: obs_* events, exp_valid/exp_rec/exp_ready);
//        done, fail, inst_cnt, err_cnt status outputs.
// Optional: TRACE_CHECK_CAPTURE_EN adds bad_inum/bad_obs/bad_exp first-mismatch capture.
module trace_checker
   import trace_checker_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter bit          STOP_ON_ERR = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   trace_checker_if.slave       tif,
   output logic                 done,
   output logic                 fail,
   output logic [31:0]          inst_cnt,
   output logic [15:0]          err_cnt
`ifdef TRACE_CHECK_CAPTURE_EN
   ,
   output logic [31:0]          bad_inum,
   output logic [REC_W-1:0]     bad_obs,
   output logic [REC_W-1:0]     bad_exp
`endif
);
   state_e     state;
   state_e     state_nxt;
   trace_rec_t obs_rec;
   trace_rec_t head;
   logic       full;
   logic       empty;
   logic       hlt_seen;
   logic       push;
   logic       pop;
   logic       overflow;
   logic       mismatch;
   logic       hlt_cmp;

   // Classify the retire event; fields a type does not use stay zero
   always_comb begin
      obs_rec    = '0;
      obs_rec.pc = tif.obs_pc;
      if (tif.obs_regwr && tif.obs_memrd) begin
         obs_rec.typ   = TR_LD;
         obs_rec.rg    = tif.obs_wreg;
         obs_rec.value = tif.obs_wdata;
         obs_rec.addr  = tif.obs_addr;
      end else if (tif.obs_regwr) begin
         obs_rec.typ   = TR_REG;
         obs_rec.rg    = tif.obs_wreg;
         obs_rec.value = tif.obs_wdata;
      end else if (tif.obs_hlt) begin
         obs_rec.typ   = TR_HLT;
      end else if (tif.obs_memwr) begin
         obs_rec.typ   = TR_ST;
         obs_rec.value = tif.obs_mdata;
         obs_rec.addr  = tif.obs_addr;
      end else begin
         obs_rec.typ   = TR_NOP;
      end
   end

   assign push     = tif.obs_en && (state == ST_RUN) && !hlt_seen;
   assign pop      = (state == ST_RUN) && !empty && tif.exp_valid;
   assign overflow = push && full && !pop;
   assign mismatch = pop && (head != tif.exp_rec);
   assign hlt_cmp  = (head.typ == TR_HLT) || (tif.exp_rec.typ == TR_HLT);

   assign tif.exp_ready = pop;

   trace_checker_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push && !overflow),
      .wr_data   (obs_rec),
      .pop       (pop),
      .rd_data_c (head),
      .full_c    (full),
      .empty_c   (empty)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // FSM next state; a mismatched HLT always stops the run
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_RUN: begin
            if (overflow)
               state_nxt = ST_FAIL;
            else if (mismatch) begin
               if (STOP_ON_ERR || hlt_cmp) state_nxt = ST_FAIL;
            end else if (pop && (head.typ == TR_HLT))
               state_nxt = ST_DONE;
         end
         default: state_nxt = state;
      endcase
   end

   // Registered status, counters and HLT-push tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done     <= 1'b0;
         fail     <= 1'b0;
         inst_cnt <= '0;
         err_cnt  <= '0;
         hlt_seen <= 1'b0;
      end else begin
         done <= (state_nxt == ST_DONE);
         fail <= (state_nxt == ST_FAIL);
         if (pop) inst_cnt <= inst_cnt + 32'd1;
         if (mismatch && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
         if (push && (obs_rec.typ == TR_HLT)) hlt_seen <= 1'b1;
      end
   end

`ifdef TRACE_CHECK_CAPTURE_EN
   logic cap_done;

   // Latch the first mismatching pair and its record index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_done <= 1'b0;
         bad_inum <= '0;
         bad_obs  <= '0;
         bad_exp  <= '0;
      end else if (mismatch && !cap_done) begin
         cap_done <= 1'b1;
         bad_inum <= inst_cnt;
         bad_obs  <= head;
         bad_exp  <= tif.exp_rec;
      end
   end
`endif

endmodule

// File: tb/tb_trace_checker.sv
// Directed self-checking bench for trace_checker (DEPTH=8, STOP_ON_ERR=1).
module tb_trace_checker;
   import trace_checker_pkg::*;

   logic        clk;
   logic        rst;
   logic        done;
   logic        fail;
   logic [31:0] inst_cnt;
   logic [15:0] err_cnt;
`ifdef TRACE_CHECK_CAPTURE_EN
   logic [31:0]      bad_inum;
   logic [REC_W-1:0] bad_obs;
   logic [REC_W-1:0] bad_exp;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   trace_checker_if tif ();

   trace_checker #(.DEPTH(8), .STOP_ON_ERR(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .tif      (tif),
      .done     (done),
      .fail     (fail),
      .inst_cnt (inst_cnt),
      .err_cnt  (err_cnt)
`ifdef TRACE_CHECK_CAPTURE_EN
      ,
      .bad_inum (bad_inum),
      .bad_obs  (bad_obs),
      .bad_exp  (bad_exp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic trace_rec_t mk(input tr_type_e t, input logic [15:0] pc,
                                     input logic [3:0] rg, input logic [15:0] v,
                                     input logic [15:0] a);
      trace_rec_t r;
      r.typ = t; r.pc = pc; r.rg = rg; r.value = v; r.addr = a;
      return r;
   endfunction

   task automatic idle_obs();
      tif.obs_en = 1'b0; tif.obs_pc = '0; tif.obs_regwr = 1'b0; tif.obs_wreg = '0;
      tif.obs_wdata = '0; tif.obs_memrd = 1'b0; tif.obs_memwr = 1'b0;
      tif.obs_addr = '0; tif.obs_mdata = '0; tif.obs_hlt = 1'b0;
   endtask

   task automatic drive_obs(input logic [15:0] pc, input logic regwr, input logic memrd,
                            input logic memwr, input logic hlt, input logic [3:0] wreg,
                            input logic [15:0] wdata, input logic [15:0] addr,
                            input logic [15:0] mdata);
      tif.obs_en = 1'b1; tif.obs_pc = pc; tif.obs_regwr = regwr; tif.obs_memrd = memrd;
      tif.obs_memwr = memwr; tif.obs_hlt = hlt; tif.obs_wreg = wreg;
      tif.obs_wdata = wdata; tif.obs_addr = addr; tif.obs_mdata = mdata;
   endtask

   task automatic set_exp(input logic v, input trace_rec_t r);
      tif.exp_valid = v;
      tif.exp_rec   = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_obs();
      set_exp(1'b0, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
      n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL reset_fail: got %0b expected 0", fail); end
      n_checks++; if (inst_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %0d expected 0", inst_cnt); end
      n_checks++; if (err_cnt !== 16'd0)  begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
      n_checks++; if (tif.exp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", tif.exp_ready); end
`ifdef TRACE_CHECK_CAPTURE_EN
      n_checks++; if (bad_inum !== 32'd0) begin n_fail++; $display("FAIL reset_bad_inum: got %0h expected 0", bad_inum); end
`endif
   endtask

   task automatic test_reg_match();
      @(negedge clk);
      drive_obs(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h1234, 16'h0000, 16'h0000);
      set_exp(1'b1, mk(TR_REG, 16'h0002, 4'd3, 16'h1234, 16'h0000));
      #1;
      n_checks++; if (tif.exp_ready !== 1'b0) begin n_fail++; $display("FAIL reg_latency_ready: got %0b expected 0", tif.exp_ready); end
      @(negedge clk);
      idle_obs();
      #1;
      n_checks++; if (tif.exp_ready !== 1'b1) begin n_fail++; $display("FAIL reg_ready: got %0b expected 1", tif.exp_ready); end
      @(negedge clk);
      n_checks++; if (tif.exp_ready !== 1'b0) begin n_fail++; $display("FAIL reg_ready_empty: got %0b expected 0", tif.exp_ready); end
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL reg_inst: got %0d expected 1", inst_cnt); end
      n_checks++; if (err_cnt !== 16'd0)  begin n_fail++; $display("FAIL reg_err: got %0d expected 0", err_cnt); end
      set_exp(1'b0, '0);
   endtask

   task automatic test_ld_st();
      @(negedge clk);
      drive_obs(16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'hBEEF, 16'h0010, 16'h7777);
      @(negedge clk);
      // store carries stray regwr-side data that must be zeroed
      drive_obs(16'h0006, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 16'h5555, 16'h0012, 16'h00AA);
      set_exp(1'b1, mk(TR_LD, 16'h0004, 4'd2, 16'hBEEF, 16'h0010));
      @(negedge clk);
      idle_obs();
      n_checks++; if (inst_cnt !== 32'd2) begin n_fail++; $display("FAIL ld_inst: got %0d expected 2", inst_cnt); end
      set_exp(1'b1, mk(TR_ST, 16'h0006, 4'd0, 16'h00AA, 16'h0012));
      #1;
      n_checks++; if (tif.exp_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready: got %0b expected 1", tif.exp_ready); end
      @(negedge clk);
      set_exp(1'b0, '0);
      n_checks++; if (inst_cnt !== 32'd3) begin n_fail++; $display("FAIL st_inst: got %0d expected 3", inst_cnt); end
      n_checks++; if (err_cnt !== 16'd0)  begin n_fail++; $display("FAIL st_err: got %0d expected 0", err_cnt); end
      n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL st_fail: got %0b expected 0", fail); end
   endtask

   task automatic test_mismatch();
      do_reset();
      @(negedge clk);
      drive_obs(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h1234, 16'h0000, 16'h0000);
      @(negedge clk);
      idle_obs();
      set_exp(1'b1, mk(TR_REG, 16'h0008, 4'd3, 16'h1235, 16'h0000));
      @(negedge clk);
      set_exp(1'b0, '0);
      n_checks++; if (fail !== 1'b1)      begin n_fail++; $display("FAIL mm_fail: got %0b expected 1", fail); end
      n_checks++; if (err_cnt !== 16'd1)  begin n_fail++; $display("FAIL mm_err: got %0d expected 1", err_cnt); end
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL mm_inst: got %0d expected 1", inst_cnt); end
`ifdef TRACE_CHECK_CAPTURE_EN
      n_checks++; if (bad_inum !== 32'd0) begin n_fail++; $display("FAIL mm_bad_inum: got %0h expected 0", bad_inum); end
      n_checks++; if (bad_obs !== REC_W'(mk(TR_REG, 16'h0008, 4'd3, 16'h1234, 16'h0000)))
         begin n_fail++; $display("FAIL mm_bad_obs: got %0h", bad_obs); end
      n_checks++; if (bad_exp !== REC_W'(mk(TR_REG, 16'h0008, 4'd3, 16'h1235, 16'h0000)))
         begin n_fail++; $display("FAIL mm_bad_exp: got %0h", bad_exp); end
`endif
      drive_obs(16'h000A, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0001, 16'h0000, 16'h0000);
      @(negedge clk);
      idle_obs();
      set_exp(1'b1, mk(TR_REG, 16'h000A, 4'd1, 16'h0001, 16'h0000));
      #1;
      n_checks++; if (tif.exp_ready !== 1'b0) begin n_fail++; $display("FAIL mm_ready_after: got %0b expected 0", tif.exp_ready); end
      @(negedge clk);
      set_exp(1'b0, '0);
      n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL mm_sticky: got %0b expected 1", fail); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_obs(16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 16'hFFFF, 16'h0ABC, 16'h0DEF);
      end
      @(negedge clk);
      idle_obs();
      n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL bp_full_nofail: got %0b expected 0", fail); end
      drive_obs(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      idle_obs();
      n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %0b expected 1", fail); end

      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_obs(16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
      end
      @(negedge clk);
      drive_obs(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
      set_exp(1'b1, mk(TR_NOP, 16'h0000, 4'd0, 16'h0000, 16'h0000));
      #1;
      n_checks++; if (tif.exp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pushpop_ready: got %0b expected 1", tif.exp_ready); end
      @(negedge clk);
      idle_obs();
      n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL bp_pushpop_fail: got %0b expected 0", fail); end
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL bp_pushpop_inst: got %0d expected 1", inst_cnt); end
      for (int i = 1; i <= 8; i++) begin
         set_exp(1'b1, mk(TR_NOP, 16'(i), 4'd0, 16'h0000, 16'h0000));
         @(negedge clk);
      end
      set_exp(1'b0, '0);
      n_checks++; if (inst_cnt !== 32'd9) begin n_fail++; $display("FAIL bp_drain_inst: got %0d expected 9", inst_cnt); end
      n_checks++; if (err_cnt !== 16'd0)  begin n_fail++; $display("FAIL bp_drain_err: got %0d expected 0", err_cnt); end
      n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL bp_drain_fail: got %0b expected 0", fail); end
   endtask

   task automatic test_hlt();
      do_reset();
      @(negedge clk);
      drive_obs(16'h001E, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h4321, 16'h0040, 16'h0050);
      @(negedge clk);
      drive_obs(16'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0001, 16'h0000, 16'h0000);
      set_exp(1'b1, mk(TR_HLT, 16'h001E, 4'd0, 16'h0000, 16'h0000));
      @(negedge clk);
      idle_obs();
      set_exp(1'b1, mk(TR_REG, 16'h0020, 4'd1, 16'h0001, 16'h0000));
      #1;
      n_checks++; if (done !== 1'b1)      begin n_fail++; $display("FAIL hlt_done: got %0b expected 1", done); end
      n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL hlt_fail: got %0b expected 0", fail); end
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL hlt_inst: got %0d expected 1", inst_cnt); end
      n_checks++; if (tif.exp_ready !== 1'b0) begin n_fail++; $display("FAIL hlt_ready_after: got %0b expected 0", tif.exp_ready); end
      @(negedge clk);
      set_exp(1'b0, '0);
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL hlt_ignored: got %0d expected 1", inst_cnt); end

      do_reset();
      @(negedge clk);
      drive_obs(16'h001E, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      idle_obs();
      set_exp(1'b1, mk(TR_HLT, 16'h001C, 4'd0, 16'h0000, 16'h0000));
      @(negedge clk);
      set_exp(1'b0, '0);
      n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL hlt_mm_fail: got %0b expected 1", fail); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hlt_mm_done: got %0b expected 0", done); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         drive_obs(16'(2*i), 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'(16'h0011 * i), 16'h0000, 16'h0000);
      end
      @(negedge clk);
      idle_obs();
      set_exp(1'b1, mk(TR_REG, 16'h0002, 4'd1, 16'h0011, 16'h0000));
      @(negedge clk);
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL rmr_pre_inst: got %0d expected 1", inst_cnt); end
      set_exp(1'b1, mk(TR_REG, 16'h0004, 4'd1, 16'h0022, 16'h0000));
      rst = 1'b1;
      #1;
      n_checks++; if (inst_cnt !== 32'd0) begin n_fail++; $display("FAIL rmr_inst: got %0d expected 0", inst_cnt); end
      n_checks++; if (tif.exp_ready !== 1'b0) begin n_fail++; $display("FAIL rmr_empty_ready: got %0b expected 0", tif.exp_ready); end
      @(negedge clk);
      rst = 1'b0;
      set_exp(1'b0, '0);
      @(negedge clk);
      drive_obs(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h1234, 16'h0000, 16'h0000);
      @(negedge clk);
      idle_obs();
      set_exp(1'b1, mk(TR_REG, 16'h0002, 4'd3, 16'h1234, 16'h0000));
      @(negedge clk);
      set_exp(1'b0, '0);
      n_checks++; if (inst_cnt !== 32'd1) begin n_fail++; $display("FAIL rmr_fresh_inst: got %0d expected 1", inst_cnt); end
      n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL rmr_fresh_fail: got %0b expected 0", fail); end
      n_checks++; if (err_cnt !== 16'd0)  begin n_fail++; $display("FAIL rmr_fresh_err: got %0d expected 0", err_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      idle_obs();
      set_exp(1'b0, '0);
      test_reset();
      test_reg_match();
      test_ld_st();
      test_mismatch();
      test_backpressure();
      test_hlt();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
